// File: rtl/seqser_8_if.sv
// rtl/seqser_8_if.sv - byte input handshake and serial output bundle for seqser_8
interface seqser_8_if #(
  parameter int DEPTH = 2
) ();
  localparam int LW = $clog2(DEPTH + 1);

  logic [7:0]    InData;
  logic          InValid;
  logic          InReady;
  logic          SerOut;
  logic          BitValid;
  logic          ByteStart;
  logic [LW-1:0] Level;

  // Producer / observer side
  modport master (
    output InData,
    output InValid,
    input  InReady,
    input  SerOut,
    input  BitValid,
    input  ByteStart,
    input  Level
  );

  // Serializer side
  modport slave (
    input  InData,
    input  InValid,
    output InReady,
    output SerOut,
    output BitValid,
    output ByteStart,
    output Level
  );
endinterface

// File: rtl/seqser_8.sv
// rtl/seqser_8.sv - byte FIFO feeding an MSB-first serial shifter with gapless byte chaining
module seqser_8 #(
  parameter int   DEPTH    = 2,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  seqser_8_if.slave  bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // FIFO storage and pointers
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  // Shifter state; shreg holds only the bits still to be sent after SerOut
  logic [0:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [6:0]    shreg_q, shreg_d;
  logic          ser_q, ser_d;
  logic          bv_q, bv_d;
  logic          bs_q, bs_d;

  logic          in_ready;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [7:0]    head;

  // InReady depends on stored occupancy only, and drops while reset is held
  assign in_ready   = Reset && (level_q != LW'(DEPTH));
  assign push       = bus.InValid && in_ready;
  assign fifo_empty = (level_q == '0);
  assign head       = mem_q[rd_ptr_q];

  assign bus.InReady   = in_ready;
  assign bus.SerOut    = ser_q;
  assign bus.BitValid  = bv_q;
  assign bus.ByteStart = bs_q;
  assign bus.Level     = level_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Shifter next state: load from FIFO head when idle or on the last bit, else shift
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    ser_d   = ser_q;
    bv_d    = bv_q;
    bs_d    = bs_q;
    pop     = 1'b0;
    if (state_q == ST_SHIFT && cnt_q != 3'd7) begin
      shreg_d = {shreg_q[5:0], 1'b0};
      ser_d   = shreg_q[6];
      cnt_d   = cnt_q + 3'd1;
      bv_d    = 1'b1;
      bs_d    = 1'b0;
    end else if (!fifo_empty) begin
      pop     = 1'b1;
      state_d = ST_SHIFT;
      cnt_d   = 3'd0;
      shreg_d = head[6:0];
      ser_d   = head[7];
      bv_d    = 1'b1;
      bs_d    = 1'b1;
    end else begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
      ser_d   = IDLE_BIT;
      bv_d    = 1'b0;
      bs_d    = 1'b0;
    end
  end

  // FIFO pointer and occupancy bookkeeping; simultaneous push and pop leave Level unchanged
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FIFO data is written only on accepted bytes, so idle-cycle InData never enters storage
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.InData;
    end
  end

  // State registers; reset drops any byte in flight and everything queued
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      shreg_q  <= '0;
      ser_q    <= IDLE_BIT;
      bv_q     <= 1'b0;
      bs_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      ser_q    <= ser_d;
      bv_q     <= bv_d;
      bs_q     <= bs_d;
    end
  end
endmodule

// File: tb/tb_seqser_8.sv
// tb/tb_seqser_8.sv - directed vector bench for seqser_8
module tb_seqser_8;
  logic clk;
  logic rst_n;

  seqser_8_if #(.DEPTH(2)) bus ();

  seqser_8 #(.DEPTH(2), .IDLE_BIT(1'b0)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_bits;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // producer schedule and collected observations
  logic [7:0]  q_data  [8];
  int          q_start [8];
  logic [63:0] s_bits;
  logic [63:0] s_bs;
  int          first_bv, last_bv, bv_count, bs_stray, max_lvl, stalls, accepted;
  int          lvl_hist [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // runs ncyc cycles: samples outputs at each falling edge, then drives the next offer
  task automatic run(input int nb, input int ncyc);
    int idx;
    idx      = 0;
    s_bits   = '0;
    s_bs     = '0;
    first_bv = -1;
    last_bv  = -1;
    bv_count = 0;
    bs_stray = 0;
    max_lvl  = 0;
    stalls   = 0;
    for (int c = 0; c <= ncyc; c++) begin
      @(negedge clk);
      if (bus.BitValid) begin
        s_bits = {s_bits[62:0], bus.SerOut};
        s_bs   = {s_bs[62:0], bus.ByteStart};
        if (first_bv < 0) first_bv = c;
        last_bv = c;
        bv_count++;
      end else if (bus.ByteStart) begin
        bs_stray++;
      end
      lvl_hist[c] = int'(bus.Level);
      if (int'(bus.Level) > max_lvl) max_lvl = int'(bus.Level);
      if (c < ncyc && idx < nb && c + 1 >= q_start[idx]) begin
        bus.InValid = 1'b1;
        bus.InData  = q_data[idx];
        if (bus.InReady) idx++;
        else stalls++;
      end else begin
        bus.InValid = 1'b0;
        bus.InData  = 8'hxx;
      end
    end
    bus.InValid = 1'b0;
    accepted = idx;
  endtask

  vec_t tbl [5];

  initial begin
    tbl[0] = '{8'h42, 8'b01000010};
    tbl[1] = '{8'hFF, 8'b11111111};
    tbl[2] = '{8'h00, 8'b00000000};
    tbl[3] = '{8'h81, 8'b10000001};
    tbl[4] = '{8'h5A, 8'b01011010};

    rst_n       = 1'b0;
    bus.InValid = 1'b0;
    bus.InData  = 8'h00;
    #1;
    chk("rst_serout",    bus.SerOut,    1'b0);
    chk("rst_bitvalid",  bus.BitValid,  1'b0);
    chk("rst_bytestart", bus.ByteStart, 1'b0);
    chk("rst_level",     bus.Level,     2'd0);
    chk("rst_inready",   bus.InReady,   1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_inready", bus.InReady, 1'b1);

    // single bytes from the table
    for (int i = 0; i < 5; i++) begin
      q_data[0]  = tbl[i].data;
      q_start[0] = 1;
      run(1, 12);
      chk($sformatf("single_%0h_stream", tbl[i].data), s_bits[7:0], tbl[i].exp_bits);
      chk($sformatf("single_%0h_bvcount", tbl[i].data), bv_count, 8);
      chk($sformatf("single_%0h_latency", tbl[i].data), first_bv, 2);
      chk($sformatf("single_%0h_bytestart", tbl[i].data), s_bs[7:0], 8'h80);
      chk($sformatf("single_%0h_bsstray", tbl[i].data), bs_stray, 0);
      chk($sformatf("single_%0h_idlebit", tbl[i].data), bus.SerOut, 1'b0);
      chk($sformatf("single_%0h_level", tbl[i].data), bus.Level, 2'd0);
    end

    // back-to-back with held InValid: also exercises backpressure on a full FIFO
    q_data[0] = 8'h85; q_data[1] = 8'h97; q_data[2] = 8'h42; q_data[3] = 8'h53; q_data[4] = 8'h28;
    for (int i = 0; i < 5; i++) q_start[i] = 1;
    run(5, 46);
    chk("b2b_stream",    s_bits[39:0], 40'h8597425328);
    chk("b2b_bvcount",   bv_count, 40);
    chk("b2b_first",     first_bv, 2);
    chk("b2b_last",      last_bv, 41);
    chk("b2b_bytestart", s_bs[39:0], 40'h8080808080);
    chk("b2b_maxlevel",  max_lvl, 2);
    chk("b2b_stalls",    stalls, 14);
    chk("b2b_accepted",  accepted, 5);
    chk("b2b_full_lvl",  lvl_hist[5], 2);

    // push on the same edge as the counter=7 pop with one byte queued
    q_data[0] = 8'hC3; q_data[1] = 8'h96; q_data[2] = 8'h3C;
    q_start[0] = 1; q_start[1] = 2; q_start[2] = 10;
    run(3, 30);
    chk("coll_lvl_before", lvl_hist[9], 1);
    chk("coll_lvl_after",  lvl_hist[10], 1);
    chk("coll_stream",     s_bits[23:0], 24'hC3963C);
    chk("coll_bvcount",    bv_count, 24);
    chk("coll_last",       last_bv, 25);
    chk("coll_bytestart",  s_bs[23:0], 24'h808080);
    chk("coll_stalls",     stalls, 0);

    // reset after three bits of 0xA5 with 0x3C queued
    q_data[0] = 8'hA5; q_data[1] = 8'h3C;
    q_start[0] = 1; q_start[1] = 2;
    run(2, 4);
    chk("mid_bits",    s_bits[2:0], 3'b101);
    chk("mid_bvcount", bv_count, 3);
    chk("mid_level",   lvl_hist[4], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_serout",    bus.SerOut,    1'b0);
    chk("mid_rst_bitvalid",  bus.BitValid,  1'b0);
    chk("mid_rst_bytestart", bus.ByteStart, 1'b0);
    chk("mid_rst_level",     bus.Level,     2'd0);
    chk("mid_rst_inready",   bus.InReady,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_inready", bus.InReady, 1'b1);
    q_data[0]  = 8'h01;
    q_start[0] = 1;
    run(1, 14);
    chk("after_rst_stream",    s_bits[7:0], 8'h01);
    chk("after_rst_bvcount",   bv_count, 8);
    chk("after_rst_first",     first_bv, 2);
    chk("after_rst_bytestart", s_bs[7:0], 8'h80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seqser_8.md
SEQSER_8 -- requirements
Module: seqser_8

Interface
REQ-001 SHALL have parameter DEPTH, default 2, input FIFO depth in bytes (legal: 2..8).
REQ-002 SHALL have parameter IDLE_BIT, default 1'b0, SerOut value when no byte is shifting.
REQ-003 SHALL have port Clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port InData  input  8  byte to serialize, sampled only on an accept edge.
REQ-006 SHALL have port InValid  input  1  producer offers InData.
REQ-007 SHALL have port InReady  output  1  block can accept a byte this cycle.
REQ-008 SHALL have port SerOut  output  1  serial bit stream, MSB first, registered.
REQ-009 SHALL have port BitValid  output  1  SerOut carries a data bit this cycle, registered.
REQ-010 SHALL have port ByteStart  output  1  high only while SerOut carries bit 7 of a byte, registered.
REQ-011 SHALL have port Level  output  clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-012 SHALL accept a byte at a rising edge iff InValid=1 and InReady=1; accepted bytes enter FIFO in order.
REQ-013 SHALL drive InReady = (Level != DEPTH) while Reset=1, combinational from registered occupancy only (no path from InValid).
REQ-014 SHALL implement shifter FSM with states IDLE and SHIFT plus 3-bit bit counter.
REQ-015 IDLE, FIFO non-empty at edge: pop head into shift register, go SHIFT, counter=0; SerOut=bit7, BitValid=1, ByteStart=1 after that edge.
REQ-016 SHIFT, counter<7 at edge: shift left, counter+1; SerOut=next lower bit, ByteStart=0.
REQ-017 SHIFT, counter=7, FIFO non-empty at edge: load next head, counter=0, stay SHIFT; no gap cycle between bytes.
REQ-018 SHIFT, counter=7, FIFO empty at edge: go IDLE; SerOut=IDLE_BIT, BitValid=0, ByteStart=0.
REQ-019 SHALL not bypass the FIFO: byte accepted at edge t into empty FIFO with shifter IDLE appears as bit7 after edge t+1, bit0 after edge t+8.
REQ-020 Simultaneous accept and pop in same edge: Level unchanged, both operations take effect.
REQ-021 Full FIFO (Level=DEPTH): InReady=0; pop at edge frees a slot, InReady=1 the following cycle.
REQ-022 Empty FIFO: pop SHALL never occur; Level SHALL never underflow or exceed DEPTH.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH without loss or duplication of bytes.
REQ-024 InData SHALL be ignored on non-accept cycles; X on InData with InValid=0 SHALL not propagate.

Reset
REQ-025 Reset=0 SHALL immediately (asynchronously) force: FSM=IDLE, counter=0, Level=0, SerOut=IDLE_BIT, BitValid=0, ByteStart=0, InReady=0.
REQ-026 Reset asserted mid-byte or with FIFO non-empty SHALL discard all pending bits and bytes; no partial resumption.
REQ-027 After Reset deasserts, InReady SHALL be 1 from the first cycle; first accepted byte starts at bit7.

Verification
REQ-028 Single byte: after reset, offer 0x42 one cycle -> after edges t+1..t+8 SerOut = 0,1,0,0,0,0,1,0; BitValid=1 for exactly 8 cycles; ByteStart=1 only first of them; then SerOut=IDLE_BIT.
REQ-029 Back-to-back: InValid held with 0x85,0x97,0x42,0x53,0x28 -> 40 contiguous BitValid cycles, stream = 10000101 10010111 01000010 01010011 00101000; ByteStart pulses at bits 0,8,16,24,32.
REQ-030 Backpressure: InValid held high, slow drain -> Level reaches 2, InReady=0, offered byte held and accepted only after pop; no byte lost or duplicated.
REQ-031 Push/pop collision: Level=1, byte accepted on same edge as pop at counter=7 -> Level stays 1, next byte follows with no gap.
REQ-032 Reset mid-byte: assert Reset after 3 bits of 0xA5 with 0x3C queued -> SerOut=IDLE_BIT, BitValid=0, Level=0 without waiting for an edge; after release, offer 0x01 -> stream 00000001 only.
